// File: rtl/bcd_mod_counter.sv
// Multi-digit packed-BCD modulo counter (0..MODULO-1, up/down) with load, enable and a
// cascade terminal-count pulse. Optional enable prescaler is built only when BCD_CNT_PRESCALE_EN is defined.
module bcd_mod_counter #(
    parameter int DIGITS   = 2,
    parameter int MODULO   = 60,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rs,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    // Elaboration-time parameter range checks.
    generate
        if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
            $error("bcd_mod_counter: DIGITS must be in 1..9");
        end
        if (MODULO < 2 || MODULO > 10**DIGITS) begin : g_bad_modulo
            $error("bcd_mod_counter: MODULO must be in 2..10**DIGITS");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("bcd_mod_counter: PRESCALE must be >= 1");
        end
    endgenerate

    function automatic logic [W-1:0] to_bcd(input int unsigned value);
        logic [W-1:0] result;
        int unsigned  rest;
        result = '0;
        rest   = value;
        for (int i = 0; i < DIGITS; i++) begin
            result[4*i +: 4] = 4'(rest % 10);
            rest             = rest / 10;
        end
        return result;
    endfunction

    // With every digit <= 9, packed-BCD order equals unsigned order, so limits compare directly.
    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULO - 1);

    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0]      inc_val;
    logic [W-1:0]      dec_val;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic [DIGITS-1:0] digit_ok;
    logic              load_legal;
    logic              at_max;
    logic              at_zero;
    logic              step;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            assign cur = count_q[4*gi +: 4];

            assign inc_val[4*gi +: 4] = carry[gi]  ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1) : cur;
            assign dec_val[4*gi +: 4] = borrow[gi] ? ((cur == 4'd0) ? 4'd9 : cur - 4'd1) : cur;

            if (gi < DIGITS - 1) begin : g_chain
                assign carry[gi+1]  = carry[gi]  & (cur == 4'd9);
                assign borrow[gi+1] = borrow[gi] & (cur == 4'd0);
            end

            assign digit_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);
        end
    endgenerate

    assign load_legal = (&digit_ok) && (load_val <= MAX_BCD);
    assign at_max     = (count_q == MAX_BCD);
    assign at_zero    = (count_q == '0);

`ifdef BCD_CNT_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            ps_tick;

    assign ps_tick = (ps_q == PS_LAST);
    assign step    = en & ps_tick;

    // Prescaler phase freezes while en is low; load restarts it from zero.
    always_comb begin
        ps_d = ps_q;
        if (load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = ps_tick ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign step = en;
`endif

    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_legal) begin
                count_d = load_val;
            end else begin
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (step) begin
            if (up_dn) begin
                count_d = at_max ? '0 : inc_val;
                tc_d    = at_max;
            end else begin
                count_d = at_zero ? MAX_BCD : dec_val;
                tc_d    = at_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: a 2-digit mod-60 instance and a 3-digit mod-1000
// instance with PRESCALE=4 (prescaler active only when BCD_CNT_PRESCALE_EN is defined).
module tb_bcd_mod_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rs, en, up_dn, load;
    logic [7:0]  load_val;
    logic [7:0]  count;
    logic        tc, load_err;

    logic        rs3, en3, up3, load3;
    logic [11:0] lv3;
    logic [11:0] count3;
    logic        tc3, err3;

    int checks = 0;
    int errors = 0;

    bcd_mod_counter #(.DIGITS(2), .MODULO(60), .PRESCALE(1)) u_dut (
        .clk(clk), .rs(rs), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .load_err(load_err)
    );

    bcd_mod_counter #(.DIGITS(3), .MODULO(1000), .PRESCALE(4)) u_dut3 (
        .clk(clk), .rs(rs3), .en(en3), .up_dn(up3), .load(load3), .load_val(lv3),
        .count(count3), .tc(tc3), .load_err(err3)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic e, input logic u, input logic [7:0] v);
        rs = r; load = l; en = e; up_dn = u; load_val = v;
        @(posedge clk); #1;
    endtask

    task automatic exp2(input string tag, input logic [7:0] c, input logic t, input logic le);
        $display("step %s: count=%h tc=%b load_err=%b", tag, count, tc, load_err);
        chk({tag, "_count"}, {4'h0, count}, {4'h0, c});
        chk({tag, "_tc"}, {11'h0, tc}, {11'h0, t});
        chk({tag, "_err"}, {11'h0, load_err}, {11'h0, le});
    endtask

    task automatic cyc3(input logic r, input logic l, input logic e, input logic u, input logic [11:0] v);
        rs3 = r; load3 = l; en3 = e; up3 = u; lv3 = v;
        @(posedge clk); #1;
    endtask

    task automatic exp3(input string tag, input logic [11:0] c, input logic t);
        $display("step %s: count3=%h tc3=%b err3=%b", tag, count3, tc3, err3);
        chk({tag, "_count"}, count3, c);
        chk({tag, "_tc"}, {11'h0, tc3}, {11'h0, t});
    endtask

    initial begin
        rs3 = 1'b1; load3 = 1'b0; en3 = 1'b0; up3 = 1'b1; lv3 = 12'h000;

        // Reset dominates simultaneous load and enable.
        cyc(1, 1, 1, 1, 8'h42); exp2("rst1", 8'h00, 0, 0);
        cyc(1, 1, 1, 1, 8'h42); exp2("rst2", 8'h00, 0, 0);
        rs3 = 1'b0;

        // Up wrap at 59.
        cyc(0, 1, 0, 1, 8'h58); exp2("up_load", 8'h58, 0, 0);
        cyc(0, 0, 1, 1, 8'h00); exp2("up1", 8'h59, 0, 0);
        cyc(0, 0, 1, 1, 8'h00); exp2("up2_wrap", 8'h00, 1, 0);
        cyc(0, 0, 1, 1, 8'h00); exp2("up3", 8'h01, 0, 0);

        // Down wrap at 00.
        cyc(0, 1, 0, 0, 8'h01); exp2("dn_load", 8'h01, 0, 0);
        cyc(0, 0, 1, 0, 8'h00); exp2("dn1", 8'h00, 0, 0);
        cyc(0, 0, 1, 0, 8'h00); exp2("dn2_wrap", 8'h59, 1, 0);
        cyc(0, 0, 1, 0, 8'h00); exp2("dn3", 8'h58, 0, 0);

        // Illegal and legal loads.
        cyc(0, 1, 0, 1, 8'h5A); exp2("ill_5a", 8'h00, 0, 1);
        cyc(0, 1, 0, 1, 8'h60); exp2("ill_60", 8'h00, 0, 1);
        cyc(0, 1, 0, 1, 8'h42); exp2("ld_42", 8'h42, 0, 0);
        cyc(0, 0, 0, 1, 8'h00); exp2("hold", 8'h42, 0, 0);
        cyc(0, 1, 0, 1, 8'h9F); exp2("ill_9f", 8'h00, 0, 1);
        cyc(0, 0, 0, 1, 8'h00); exp2("err_drop", 8'h00, 0, 0);

        // Simultaneous events.
        cyc(1, 1, 1, 1, 8'h33); exp2("rs_load", 8'h00, 0, 0);
        cyc(0, 1, 1, 1, 8'h33); exp2("load_en", 8'h33, 0, 0);
        cyc(0, 1, 0, 1, 8'h59); exp2("pre_wrap", 8'h59, 0, 0);
        cyc(0, 0, 1, 1, 8'h00); exp2("wrap", 8'h00, 1, 0);
        cyc(1, 0, 1, 1, 8'h00); exp2("rs_after_wrap", 8'h00, 0, 0);

        // Carry/borrow across digits and direction change.
        cyc(0, 1, 0, 1, 8'h09); exp2("ld_09", 8'h09, 0, 0);
        cyc(0, 0, 1, 1, 8'h00); exp2("carry", 8'h10, 0, 0);
        cyc(0, 0, 1, 1, 8'h00); exp2("up_11", 8'h11, 0, 0);
        cyc(0, 0, 1, 0, 8'h00); exp2("dir_10", 8'h10, 0, 0);
        cyc(0, 0, 1, 0, 8'h00); exp2("borrow", 8'h09, 0, 0);
        cyc(0, 0, 0, 1, 8'h00); exp2("en_off", 8'h09, 0, 0);

        // Three-digit instance.
        cyc3(0, 1, 0, 1, 12'h999); exp3("p_load", 12'h999, 0);
`ifdef BCD_CNT_PRESCALE_EN
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e1", 12'h999, 0);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e2", 12'h999, 0);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e3", 12'h999, 0);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e4_wrap", 12'h000, 1);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e5", 12'h000, 0);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e6", 12'h000, 0);
        cyc3(0, 0, 0, 1, 12'h000); exp3("p_gap1", 12'h000, 0);
        cyc3(0, 0, 0, 1, 12'h000); exp3("p_gap2", 12'h000, 0);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e7", 12'h000, 0);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e8_step", 12'h001, 0);
        cyc3(0, 0, 1, 1, 12'h000); exp3("p_e9", 12'h001, 0);
`else
        cyc3(0, 0, 1, 1, 12'h000); exp3("n_wrap", 12'h000, 1);
        cyc3(0, 0, 1, 1, 12'h000); exp3("n_up1", 12'h001, 0);
        cyc3(0, 0, 0, 1, 12'h000); exp3("n_hold", 12'h001, 0);
        cyc3(0, 0, 1, 0, 12'h000); exp3("n_dn0", 12'h000, 0);
        cyc3(0, 0, 1, 0, 12'h000); exp3("n_dnwrap", 12'h999, 1);
`endif
        cyc3(0, 1, 0, 1, 12'h0A0); exp3("p_ill", 12'h000, 0);
        chk("p_ill_err", {11'h0, err3}, 12'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
